// File: rtl/alu_chunked_pkg.sv
// Shared definitions for the chunked sequential ALU.
// - Op-code constants OP_ADD..OP_PASS (3-bit).
// - FSM state encoding (IDLE/BUSY/DONE).
// - Bit positions of the packed flag vector {sign, zero, carry, parity, overflow}.
// - Small helpers that classify op codes.
package alu_chunked_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SBB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_FLAGS   = 5;
  localparam int FLAG_SIGN   = 4;
  localparam int FLAG_ZERO   = 3;
  localparam int FLAG_CARRY  = 2;
  localparam int FLAG_PARITY = 1;
  localparam int FLAG_OVF    = 0;

  // Arithmetic ops all have op[2] clear.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Subtracting ops invert the Y operand before it enters the adder.
  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/alu_chunked_seq_adder_chunk.sv
// adder_chunk: combinational CHUNK-bit adder, {cout, s} = a + b + cin.
// Ports:
//   a, b  in  CHUNK  addends
//   cin   in  1      carry in
//   s     out CHUNK  sum
//   cout  out 1      carry out of the chunk MSB
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/alu_chunked_seq.sv
// alu_chunked_seq: multi-cycle ALU that walks WIDTH-bit operands CHUNK bits per
// clock through a single shared chunk adder with a registered carry.
// Handshake: a request is accepted on a rising edge where in_valid && in_ready
// (in_ready is high only in IDLE); a result is consumed on a rising edge where
// out_valid && out_ready (out_valid is high only in DONE). No request is taken
// while BUSY or DONE.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; op, cin, x, y sampled on accept
//   out_valid/out_ready result handshake
//   z                   result
//   sign/zero/carry/parity/overflow  flags registered from the complete result
module alu_chunked_seq
  import alu_chunked_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     ye_q, ye_d;
  logic                 carry_q, carry_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     z_q, z_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk, res_chunk;
  logic             sum_cout;
  logic [WIDTH-1:0] z_merge;
  logic             c0;

  assign a_chunk = x_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = ye_q[idx_q*CHUNK +: CHUNK];

  adder_chunk #(.CHUNK(CHUNK)) u_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .s    (sum_chunk),
    .cout (sum_cout)
  );

  // Per-chunk result; logic ops reuse the same slot timing as arithmetic.
  always_comb begin
    res_chunk = sum_chunk;
    case (op_q)
      OP_AND:  res_chunk = a_chunk & b_chunk;
      OP_OR:   res_chunk = a_chunk | b_chunk;
      OP_XOR:  res_chunk = a_chunk ^ b_chunk;
      OP_PASS: res_chunk = a_chunk;
      default: res_chunk = sum_chunk;
    endcase
  end

  // Result register with the current chunk written in; used both as the next
  // z value and as the complete result for flag formation on the last chunk.
  always_comb begin
    z_merge = z_q;
    z_merge[idx_q*CHUNK +: CHUNK] = res_chunk;
  end

  // Initial carry: 1 for SUB (two's complement), cin for ADC/SBB, else 0.
  always_comb begin
    c0 = 1'b0;
    case (op)
      OP_SUB:          c0 = 1'b1;
      OP_ADC, OP_SBB:  c0 = cin;
      default:         c0 = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    ye_d    = ye_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    z_d     = z_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          x_d     = x;
          ye_d    = is_sub(op) ? ~y : y;
          carry_d = c0;
          idx_d   = '0;
          z_d     = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        z_d     = z_merge;
        carry_d = is_arith(op_q) ? sum_cout : 1'b0;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d                = '0;
          state_d              = ST_DONE;
          flags_d[FLAG_SIGN]   = z_merge[WIDTH-1];
          flags_d[FLAG_ZERO]   = ~|z_merge;
          flags_d[FLAG_CARRY]  = is_arith(op_q) ? sum_cout : 1'b0;
          flags_d[FLAG_PARITY] = ~^z_merge;
          flags_d[FLAG_OVF]    = is_arith(op_q) &
                                 ((x_q[WIDTH-1] & ye_q[WIDTH-1] & ~z_merge[WIDTH-1]) |
                                  (~x_q[WIDTH-1] & ~ye_q[WIDTH-1] & z_merge[WIDTH-1]));
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      x_q     <= '0;
      ye_q    <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      z_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      ye_q    <= ye_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      z_q     <= z_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign z         = z_q;
  assign sign      = flags_q[FLAG_SIGN];
  assign zero      = flags_q[FLAG_ZERO];
  assign carry     = flags_q[FLAG_CARRY];
  assign parity    = flags_q[FLAG_PARITY];
  assign overflow  = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_alu_chunked_seq.sv
// Bench for alu_chunked_seq: directed 16-bit vector table, backpressure and
// mid-operation reset sequences, then random ops on an 8-bit/2-bit-chunk build
// checked against a whole-word reference model.
module tb_alu_chunked_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit, 4-bit chunk instance
  logic        in_valid, in_ready, cin, out_valid, out_ready;
  logic [2:0]  op;
  logic [15:0] x, y, z;
  logic        sign, zero, carry, parity, overflow;

  // 8-bit, 2-bit chunk instance
  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8;
  logic [2:0]  op8;
  logic [7:0]  x8, y8, z8;
  logic        sign8, zero8, carry8, parity8, overflow8;

  alu_chunked_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .cin(cin), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .sign(sign), .zero(zero), .carry(carry), .parity(parity),
    .overflow(overflow)
  );

  alu_chunked_seq #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .cin(cin8), .x(x8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8),
    .z(z8), .sign(sign8), .zero(zero8), .carry(carry8), .parity(parity8),
    .overflow(overflow8)
  );

  int total = 0;
  int bad   = 0;

  // flags packed as {sign, zero, carry, parity, overflow}
  typedef struct {
    logic [2:0]  op;
    logic        cin;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] exp_z;
    logic [4:0]  exp_f;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-word reference: z and flags {sign,zero,carry,parity,overflow}.
  task automatic ref_model(input int w, input logic [2:0] o, input logic ci,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rz, output logic [4:0] rf);
    logic [32:0] mask, sum;
    logic [31:0] be;
    logic        c, ov, ar;
    mask = (33'd1 << w) - 33'd1;
    be   = (o == 3'b001 || o == 3'b011) ? (~b & mask[31:0]) : b;
    c    = (o == 3'b001) ? 1'b1 : ((o == 3'b010 || o == 3'b011) ? ci : 1'b0);
    sum  = {1'b0, a} + {1'b0, be} + {32'd0, c};
    ar   = ~o[2];
    case (o)
      3'b100:  rz = a & b;
      3'b101:  rz = a | b;
      3'b110:  rz = a ^ b;
      3'b111:  rz = a;
      default: rz = sum[31:0] & mask[31:0];
    endcase
    ov = ar & ((a[w-1] & be[w-1] & ~rz[w-1]) | (~a[w-1] & ~be[w-1] & rz[w-1]));
    rf = {rz[w-1], (rz == 32'd0), ar & sum[w], ~^rz, ov};
  endtask

  // Issue one op to the 16-bit instance, wait for the result, check, consume.
  task automatic run16(input vec_t v, input int k);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", k), in_ready, 1);
    in_valid = 1; op = v.op; cin = v.cin; x = v.x; y = v.y; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; x = 16'hDEAD; y = 16'hBEEF;  // inputs must not matter after accept
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk($sformatf("v%0d latency", k), lat, 4);
    chk($sformatf("v%0d z", k), z, v.exp_z);
    chk($sformatf("v%0d flags", k), {sign, zero, carry, parity, overflow}, v.exp_f);
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk($sformatf("v%0d out_valid drop", k), out_valid, 0);
  endtask

  task automatic run8(input int k);
    logic [2:0]  o;
    logic        ci;
    logic [7:0]  a, b;
    logic [31:0] rz;
    logic [4:0]  rf;
    int lat;
    o = 3'($urandom_range(0, 7)); ci = 1'($urandom_range(0, 1));
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    ref_model(8, o, ci, {24'd0, a}, {24'd0, b}, rz, rf);
    @(negedge clk);
    in_valid8 = 1; op8 = o; cin8 = ci; x8 = a; y8 = b; out_ready8 = 0;
    @(posedge clk); #1;
    in_valid8 = 0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk($sformatf("r%0d latency8", k), lat, 4);
    chk($sformatf("r%0d z8 op%0d", k, o), {24'd0, z8}, rz);
    chk($sformatf("r%0d flags8 op%0d", k, o), {sign8, zero8, carry8, parity8, overflow8}, rf);
    @(negedge clk); out_ready8 = 1;
    @(posedge clk); #1; out_ready8 = 0;
  endtask

  initial begin : main
    logic [15:0] hz;
    logic [4:0]  hf;
    int lat;
    vecs[0]  = '{3'b000, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 5'b10001};
    vecs[1]  = '{3'b000, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 5'b01110};
    vecs[2]  = '{3'b001, 1'b0, 16'h0005, 16'h0005, 16'h0000, 5'b01110};
    vecs[3]  = '{3'b010, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 5'b00000};
    vecs[4]  = '{3'b011, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 5'b10010};
    vecs[5]  = '{3'b110, 1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 5'b00010};
    vecs[6]  = '{3'b111, 1'b0, 16'h0001, 16'h1234, 16'h0001, 5'b00000};
    vecs[7]  = '{3'b100, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00010};
    vecs[8]  = '{3'b101, 1'b0, 16'h1200, 16'h0034, 16'h1234, 5'b00000};
    vecs[9]  = '{3'b001, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 5'b10010};
    vecs[10] = '{3'b001, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 5'b00101};
    vecs[11] = '{3'b000, 1'b1, 16'h0001, 16'h0001, 16'h0002, 5'b00000};
    vecs[12] = '{3'b000, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 5'b00000};

    rst = 1; in_valid = 0; op = 0; cin = 0; x = 0; y = 0; out_ready = 0;
    in_valid8 = 0; op8 = 0; cin8 = 0; x8 = 0; y8 = 0; out_ready8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;

    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset z", z, 0);
    chk("reset flags", {sign, zero, carry, parity, overflow}, 0);

    for (int i = 0; i < 13; i++) run16(vecs[i], i);

    // Backpressure: result must hold while out_ready is low, in_valid ignored.
    @(negedge clk);
    in_valid = 1; op = 3'b000; cin = 0; x = 16'h1234; y = 16'h1111;
    @(posedge clk); #1;
    op = 3'b110; x = 16'hFFFF; y = 16'h0F0F;  // keep requesting a different op
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp latency", lat, 4);
    hz = 16'h2345; hf = 5'b00000;  // 2345 has 6 ones -> even -> parity 1
    hf[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_valid", c), out_valid, 1);
      chk($sformatf("bp%0d in_ready", c), in_ready, 0);
      chk($sformatf("bp%0d z", c), z, hz);
      chk($sformatf("bp%0d flags", c), {sign, zero, carry, parity, overflow}, hf);
    end
    @(negedge clk); in_valid = 0; out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    chk("bp z held after release", z, hz);

    // Reset while chunk 2 is being processed: previous flags are nonzero.
    @(negedge clk);
    in_valid = 1; op = 3'b000; x = 16'h7FFF; y = 16'h0001;
    @(posedge clk); #1; in_valid = 0;   // accept
    @(posedge clk); #1;                 // chunk 0
    @(posedge clk); #1;                 // chunk 1
    rst = 1;
    @(posedge clk); #1; rst = 0;        // reset replaces chunk 2
    chk("mid-rst in_ready", in_ready, 1);
    chk("mid-rst out_valid", out_valid, 0);
    chk("mid-rst z", z, 0);
    chk("mid-rst flags", {sign, zero, carry, parity, overflow}, 0);
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    chk("mid-rst no out_valid pulse", lat, 0);

    // Run a normal op after the reset to show the block recovered.
    run16(vecs[0], 100);

    for (int i = 0; i < 24; i++) run8(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
